// File: rtl/vga_timing_gen_if.sv
// Pixel-request / VGA output bundle for vga_timing_gen.
// The generator side is master. The pixel source and the display side are slave.
interface vga_timing_gen_if #(
  parameter int CW   = 10,
  parameter int IN_W = 6
);
  logic            en;
  logic [CW-1:0]   x_out;
  logic [CW-1:0]   y_out;
  logic            fb_en_out;
  logic            draw_en_out;
  logic            frame_start;
  logic            line_start;
  logic [IN_W-1:0] r_in;
  logic [IN_W-1:0] g_in;
  logic [IN_W-1:0] b_in;
  logic            VGA_CLK;
  logic [7:0]      VGA_R;
  logic [7:0]      VGA_G;
  logic [7:0]      VGA_B;
  logic            VGA_HS;
  logic            VGA_VS;
  logic            VGA_DE;

  modport master (
    input  en, r_in, g_in, b_in,
    output x_out, y_out, fb_en_out, draw_en_out, frame_start, line_start,
           VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );

  modport slave (
    output en, r_in, g_in, b_in,
    input  x_out, y_out, fb_en_out, draw_en_out, frame_start, line_start,
           VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It issues pixel-request coordinates and delays DE and the syncs
// through a PIPE_LAT-stage line, so that they realign with the returned pixel colour.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int IN_W     = 6,
  parameter int CW       = 10
) (
  input  logic clk,
  input  logic rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x, y;
  logic          act;
  logic          de_req, hs_req, vs_req;
  logic          de_dly, hs_dly, vs_dly;
  logic          de_q, hs_q, vs_q;
  logic [7:0]    r_q, g_q, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (!bus.en) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      y <= (y == V_LAST) ? '0 : y + CW'(1);
    end else begin
      x <= x + CW'(1);
    end
  end

  // Reset also gates the combinational strobes because x and y sit at 0,0 during reset.
  assign act    = bus.en & ~rst;
  assign de_req = act & (x < H_ACT) & (y < V_ACT);
  assign hs_req = act & (x >= HS_BEG) & (x < HS_END);
  assign vs_req = act & (y >= VS_BEG) & (y < VS_END);

  assign bus.x_out       = x;
  assign bus.y_out       = y;
  assign bus.fb_en_out   = de_req;
  assign bus.draw_en_out = (y >= V_ACT);
  assign bus.line_start  = act & (x == '0);
  assign bus.frame_start = act & (x == '0) & (y == '0);
  assign bus.VGA_CLK     = clk;

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign de_dly = de_req;
      assign hs_dly = hs_req;
      assign vs_dly = vs_req;
    end else begin : g_dly
      logic [PIPE_LAT-1:0] de_sr, hs_sr, vs_sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          de_sr <= '0;
          hs_sr <= '0;
          vs_sr <= '0;
        end else begin
          de_sr <= PIPE_LAT'({de_sr, de_req});
          hs_sr <= PIPE_LAT'({hs_sr, hs_req});
          vs_sr <= PIPE_LAT'({vs_sr, vs_req});
        end
      end
      assign de_dly = de_sr[PIPE_LAT-1];
      assign hs_dly = hs_sr[PIPE_LAT-1];
      assign vs_dly = vs_sr[PIPE_LAT-1];
    end
  endgenerate

  // Syncs are carried active-high internally. Polarity is applied only at the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= 1'b0;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      de_q <= de_dly;
      hs_q <= hs_dly ^ !HS_POL;
      vs_q <= vs_dly ^ !VS_POL;
      r_q  <= de_dly ? (8'(bus.r_in) << (8 - IN_W)) : '0;
      g_q  <= de_dly ? (8'(bus.g_in) << (8 - IN_W)) : '0;
      b_q  <= de_dly ? (8'(bus.b_in) << (8 - IN_W)) : '0;
    end
  end

  assign bus.VGA_DE = de_q;
  assign bus.VGA_HS = hs_q;
  assign bus.VGA_VS = vs_q;
  assign bus.VGA_R  = r_q;
  assign bus.VGA_G  = g_q;
  assign bus.VGA_B  = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen in a small raster mode (H 8/2/2/2, V 4/1/1/1, PIPE_LAT=3).
// The reference model derives the raster position from a count of enabled cycles.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int L  = 3;
  localparam int IW = 6;
  localparam int CWB = 10;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if #(.CW(CWB), .IN_W(IW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PIPE_LAT(L), .IN_W(IW), .CW(CWB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit de;
    bit hs;
    bit vs;
  } req_t;

  req_t     pend[$];
  int       n;
  int       checks   = 0;
  int       failures = 0;
  bit [7:0] e_r, e_g, e_b;
  bit       e_de, e_hs, e_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    req_t idle;
    idle = '{de: 1'b0, hs: 1'b0, vs: 1'b0};
    n = 0;
    pend.delete();
    for (int i = 0; i < L; i++) pend.push_back(idle);
    e_de = 1'b0;
    e_hs = !HP;
    e_vs = !VP;
    e_r  = '0;
    e_g  = '0;
    e_b  = '0;
  endtask

  task automatic step(input bit en_v, input bit rst_v);
    int   x, y;
    bit   act;
    req_t cur, d;
    @(negedge clk);
    rst      = rst_v;
    bus.en   = en_v;
    bus.r_in = IW'($urandom);
    bus.g_in = IW'($urandom);
    bus.b_in = IW'($urandom);
    #1;
    if (rst_v) reset_model();
    x   = n % HT;
    y   = (n / HT) % VT;
    act = en_v && !rst_v;
    chk("x_out",       32'(bus.x_out), 32'(x));
    chk("y_out",       32'(bus.y_out), 32'(y));
    chk("fb_en_out",   32'(bus.fb_en_out), 32'(act && x < HA && y < VA));
    chk("draw_en_out", 32'(bus.draw_en_out), 32'(y >= VA));
    chk("line_start",  32'(bus.line_start), 32'(act && x == 0));
    chk("frame_start", 32'(bus.frame_start), 32'(act && x == 0 && y == 0));
    chk("VGA_DE",      32'(bus.VGA_DE), 32'(e_de));
    chk("VGA_HS",      32'(bus.VGA_HS), 32'(e_hs));
    chk("VGA_VS",      32'(bus.VGA_VS), 32'(e_vs));
    chk("VGA_R",       32'(bus.VGA_R), 32'(e_r));
    chk("VGA_G",       32'(bus.VGA_G), 32'(e_g));
    chk("VGA_B",       32'(bus.VGA_B), 32'(e_b));
    if (!rst_v) begin
      cur.de = act && x < HA && y < VA;
      cur.hs = act && x >= HA + HF && x < HA + HF + HS;
      cur.vs = act && y >= VA + VF && y < VA + VF + VS;
      pend.push_back(cur);
      d    = pend.pop_front();
      e_de = d.de;
      e_hs = HP ? d.hs : !d.hs;
      e_vs = VP ? d.vs : !d.vs;
      e_r  = d.de ? {bus.r_in, 2'b00} : 8'h00;
      e_g  = d.de ? {bus.g_in, 2'b00} : 8'h00;
      e_b  = d.de ? {bus.b_in, 2'b00} : 8'h00;
      n    = en_v ? n + 1 : 0;
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.r_in = '0;
    bus.g_in = '0;
    bus.b_in = '0;
    reset_model();

    repeat (3) step(1'b1, 1'b1);
    repeat (220) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    repeat (120) step(1'b1, 1'b0);
    repeat (61) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (110) step(1'b1, 1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0);

    @(posedge clk);
    #1;
    chk("VGA_CLK_high", 32'(bus.VGA_CLK), 32'(1));
    @(negedge clk);
    #1;
    chk("VGA_CLK_low", 32'(bus.VGA_CLK), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
